// File: rtl/mono_pkg.sv
// Shared definitions for the Monopix periphery readout: hit-word field widths,
// transmitter state encoding and the hit-word packing helper.
package mono_pkg;

   localparam int COL_W = 6;
   localparam int ROW_W = 8;
   localparam int TS_W  = 6;
   localparam int HIT_W = COL_W + ROW_W + 2 * TS_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_SHIFT = 2'd2
   } tx_state_e;

   // Hit word layout: {col, row, leading-edge ts, trailing-edge ts}
   function automatic logic [HIT_W-1:0] pack_hit(
      input logic [COL_W-1:0] col,
      input logic [ROW_W-1:0] row,
      input logic [TS_W-1:0]  le,
      input logic [TS_W-1:0]  te
   );
      return {col, row, le, te};
   endfunction

endpackage

// File: rtl/mono_tx_fifo.sv
// Synchronous hit buffer with show-ahead read data and an occupancy count.
// A write while full is accepted only when a pop happens in the same cycle.
module mono_tx_fifo #(
   parameter  int WIDTH = 26,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rd_ok   = rd_en && !empty;
   assign wr_ok   = wr_en && (!full || rd_ok);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (wr_ok)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok)
            rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mono_data_tx.sv
// Chip-side emulator of the Monopix TOKEN/FREEZE/READ/DATA readout: buffers hits,
// flags frozen hits on TOKEN and shifts one word out on DATA per accepted READ.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a legal READ edge, DATA held at 0
//   ST_WAIT  | word popped and latched, counting TX_DELAY idle cycles
//   ST_SHIFT | shifting the latched word out MSB first, one bit per cycle
module mono_data_tx
   import mono_pkg::*;
#(
   parameter int DATA_WIDTH = 26,
   parameter int FIFO_DEPTH = 16,
   parameter int TX_DELAY   = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  HIT_WR,
   input  logic [DATA_WIDTH-1:0] HIT_DATA,
   output logic                  HIT_FULL,
   input  logic                  FREEZE,
   input  logic                  READ,
   output logic                  TOKEN,
   output logic                  DATA,
   output logic [7:0]            LOST_CNT,
   output logic                  READ_ERR
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int BIT_W = $clog2(DATA_WIDTH + 1);
   localparam int DLY_W = 4;

   tx_state_e             state;
   logic                  read_q;
   logic                  rd_edge_q;
   logic                  freeze_q;
   logic [CNT_W-1:0]      frz_cnt;
   logic [CNT_W-1:0]      frz_snap;
   logic [CNT_W-1:0]      fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic [DATA_WIDTH-1:0] shreg;
   logic [BIT_W-1:0]      bit_cnt;
   logic [DLY_W-1:0]      dly_cnt;
   logic                  read_ok;
   logic                  frz_rise;
   logic                  hit_lost;

   // The READ edge is registered first, so pop and frz_cnt decrement land one
   // cycle after the edge is seen and TOKEN follows one cycle later still.
   assign read_ok  = rd_edge_q && (state == ST_IDLE) && FREEZE && (frz_cnt != '0);
   assign frz_rise = FREEZE && !freeze_q;
   assign frz_snap = fifo_count - CNT_W'(read_ok);
   assign hit_lost = HIT_WR && fifo_full && !read_ok;
   assign HIT_FULL = fifo_full;

   mono_tx_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (HIT_WR),
      .wr_data (HIT_DATA),
      .rd_en   (read_ok),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         read_q    <= 1'b0;
         rd_edge_q <= 1'b0;
         freeze_q  <= 1'b0;
         frz_cnt   <= '0;
         TOKEN     <= 1'b0;
         LOST_CNT  <= '0;
      end else begin
         read_q    <= READ;
         rd_edge_q <= READ && !read_q;
         freeze_q  <= FREEZE;

         if (!FREEZE)
            frz_cnt <= '0;
         else if (frz_rise)
            frz_cnt <= frz_snap;
         else if (read_ok)
            frz_cnt <= frz_cnt - CNT_W'(1);

         // Use the snapshot on the freeze edge so TOKEN does not dip for a cycle
         if (!FREEZE)
            TOKEN <= !fifo_empty;
         else if (frz_rise)
            TOKEN <= (frz_snap != '0);
         else
            TOKEN <= (frz_cnt != '0);

         if (hit_lost && (LOST_CNT != 8'hFF))
            LOST_CNT <= LOST_CNT + 8'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         dly_cnt  <= '0;
         DATA     <= 1'b0;
         READ_ERR <= 1'b0;
      end else begin
         if (rd_edge_q && !read_ok)
            READ_ERR <= 1'b1;

         case (state)
            ST_IDLE: begin
               DATA <= 1'b0;
               if (read_ok) begin
                  if (TX_DELAY == 0) begin
                     state   <= ST_SHIFT;
                     DATA    <= fifo_rdata[DATA_WIDTH-1];
                     shreg   <= fifo_rdata << 1;
                     bit_cnt <= BIT_W'(DATA_WIDTH - 1);
                  end else begin
                     state   <= ST_WAIT;
                     shreg   <= fifo_rdata;
                     dly_cnt <= DLY_W'(TX_DELAY - 1);
                  end
               end
            end

            ST_WAIT: begin
               if (dly_cnt == '0) begin
                  state   <= ST_SHIFT;
                  DATA    <= shreg[DATA_WIDTH-1];
                  shreg   <= shreg << 1;
                  bit_cnt <= BIT_W'(DATA_WIDTH - 1);
               end else begin
                  dly_cnt <= dly_cnt - DLY_W'(1);
               end
            end

            ST_SHIFT: begin
               if (bit_cnt == '0) begin
                  state <= ST_IDLE;
                  DATA  <= 1'b0;
               end else begin
                  DATA    <= shreg[DATA_WIDTH-1];
                  shreg   <= shreg << 1;
                  bit_cnt <= bit_cnt - BIT_W'(1);
               end
            end

            default: begin
               state <= ST_IDLE;
               DATA  <= 1'b0;
            end
         endcase
      end
   end

endmodule
